// File: rtl/imm_packer_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | imm_packer_if : handshake bundle for the RV32I immediate packer      |
// | Revision 1.0                                                         |
// +---------------------------------------------------------------------+
interface imm_packer_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [31:0]      in_imm;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  // master is the producer/consumer side, slave is the packer itself
  modport master (
    output in_valid, in_fmt, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/imm_packer.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | imm_packer : two-stage RV32I immediate range-check and field packer  |
// | Revision 1.0                                                         |
// +---------------------------------------------------------------------+
module imm_packer #(
  parameter int CNT_W = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  imm_packer_if.slave bus
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic             s1_valid_q;
  logic [2:0]       s1_fmt_q;
  logic [31:0]      s1_imm_q;
  logic [31:0]      s1_base_q;
  logic             s2_valid_q;
  logic [31:0]      s2_instr_q;
  logic             s2_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic             adv2;
  logic             in_ready;
  logic [31:0]      pack_instr;
  logic             pack_err;

  assign adv2     = !s2_valid_q || bus.out_ready;
  assign in_ready = rst_n && (!s1_valid_q || adv2);

  // Range rule: the listed upper bits must be a pure sign extension
  always_comb begin
    pack_instr = s1_base_q;
    pack_err   = 1'b1;
    case (s1_fmt_q)
      FMT_I: begin
        pack_err          = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
        pack_instr[31:20] = s1_imm_q[11:0];
      end
      FMT_S: begin
        pack_err          = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
        pack_instr[31:25] = s1_imm_q[11:5];
        pack_instr[11:7]  = s1_imm_q[4:0];
      end
      FMT_B: begin
        pack_err          = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
        pack_instr[31]    = s1_imm_q[12];
        pack_instr[30:25] = s1_imm_q[10:5];
        pack_instr[11:8]  = s1_imm_q[4:1];
        pack_instr[7]     = s1_imm_q[11];
      end
      FMT_U: begin
        pack_err          = |s1_imm_q[11:0];
        pack_instr[31:12] = s1_imm_q[31:12];
      end
      FMT_J: begin
        pack_err          = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) || s1_imm_q[0];
        pack_instr[31]    = s1_imm_q[20];
        pack_instr[30:21] = s1_imm_q[10:1];
        pack_instr[20]    = s1_imm_q[11];
        pack_instr[19:12] = s1_imm_q[19:12];
      end
      default: begin
        pack_err   = 1'b1;
        pack_instr = s1_base_q;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && bus.out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 3'd0;
      s1_imm_q   <= 32'd0;
      s1_base_q  <= 32'd0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'd0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (bus.in_valid && in_ready) begin
        s1_valid_q <= 1'b1;
        s1_fmt_q   <= bus.in_fmt;
        s1_imm_q   <= bus.in_imm;
        s1_base_q  <= bus.in_base;
      end else if (adv2) begin
        s1_valid_q <= 1'b0;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= pack_instr;
          s2_err_q   <= pack_err;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign bus.err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_packer.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_imm_packer : random and directed bench with scoreboard model      |
// | Revision 1.0                                                         |
// +---------------------------------------------------------------------+
module tb_imm_packer;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   model_cnt;
  exp_t sb_q[$];
  logic acc;
  logic got;
  logic [31:0] last_instr;
  logic        last_err;
  logic        stall_prev;
  logic [31:0] prev_instr;
  logic        prev_err;

  imm_packer_if #(.CNT_W(CNT_W)) bus ();

  imm_packer #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // Reference: range by signed bounds, packing by masks and shifts
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] im, input logic [31:0] b);
    exp_t e;
    int   s;
    s = int'(signed'(im));
    case (f)
      3'd0: begin
        e.err   = (s < -2048) || (s > 2047);
        e.instr = (b & 32'h000F_FFFF) | ((im & 32'hFFF) << 20);
      end
      3'd1: begin
        e.err   = (s < -2048) || (s > 2047);
        e.instr = (b & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      end
      3'd2: begin
        e.err   = (s < -4096) || (s > 4095) || (im % 2 != 0);
        e.instr = (b & 32'h01FF_F07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        e.err   = (im % 4096) != 0;
        e.instr = (b & 32'hFFF) | (im & 32'hFFFF_F000);
      end
      3'd4: begin
        e.err   = (s < -(1 << 20)) || (s > (1 << 20) - 1) || (im % 2 != 0);
        e.instr = (b & 32'hFFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12);
      end
      default: begin
        e.err   = 1'b1;
        e.instr = b;
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_imm();
    logic signed [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 2))
      0: ;
      1: begin
        t = t >>> (32 - $urandom_range(11, 22));
        if ($urandom_range(0, 1) == 1) t[0] = 1'b0;
      end
      default: t = t & 32'hFFFF_F000;
    endcase
    return t;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later
  task automatic cyc(input logic v, input logic [2:0] f, input logic [31:0] im,
                     input logic [31:0] b, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_fmt    = f;
    bus.in_imm    = im;
    bus.in_base   = b;
    bus.out_ready = ordy;
    #1;
    if (stall_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_instr", bus.out_instr, prev_instr);
      chk("hold_err", 32'(bus.out_err), 32'(prev_err));
    end
    chk("err_count", 32'(bus.err_count), 32'(model_cnt));
    acc = v && bus.in_ready;
    if (acc) sb_q.push_back(model(f, im, b));
    got = 1'b0;
    if (bus.out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_instr", bus.out_instr, e.instr);
        chk("out_err", 32'(bus.out_err), 32'(e.err));
      end
      got        = 1'b1;
      last_instr = bus.out_instr;
      last_err   = bus.out_err;
      if (bus.out_err && model_cnt < CNT_MAX) model_cnt++;
    end
    stall_prev = bus.out_valid && !ordy;
    prev_instr = bus.out_instr;
    prev_err   = bus.out_err;
  endtask

  task automatic flush();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("flush_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Word driven in cycle 0, accepted at the following rising edge, visible after the next one
  task automatic directed(input string tag, input logic [2:0] f, input logic [31:0] im,
                          input logic [31:0] b, input logic [31:0] exp_i, input logic exp_e);
    flush();
    cyc(1'b1, f, im, b, 1'b1);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk({tag, "_latency"}, 32'(got), 32'd1);
    chk({tag, "_instr"}, last_instr, exp_i);
    chk({tag, "_err"}, 32'(last_err), 32'(exp_e));
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] im;
    logic [31:0] b;
    int          idx;
    int          sent;
    logic [31:0] bp_imm[5];
    logic [2:0]  bp_fmt[5];

    n_chk = 0; n_fail = 0; model_cnt = 0;
    stall_prev = 1'b0; acc = 1'b0; got = 1'b0;
    last_instr = '0; last_err = 1'b0; prev_instr = '0; prev_err = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_imm = '0; bus.in_base = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    directed("i_type", 3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    directed("s_type", 3'd1, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0);
    directed("b_type", 3'd2, 32'h0000_0800, 32'h0000_0063, 32'h0000_00E3, 1'b0);
    directed("u_type", 3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    directed("j_type", 3'd4, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
    directed("u_err", 3'd3, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("err_count_one", 32'(bus.err_count), 32'd1);
    directed("b_err", 3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    directed("fmt6", 3'd6, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    // Random streaming with random backpressure; a word is held until taken
    f = 3'($urandom_range(0, 7)); im = rnd_imm(); b = $urandom;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), f, im, b, ($urandom_range(0, 9) < 7));
      if (acc) begin
        f = 3'($urandom_range(0, 7)); im = rnd_imm(); b = $urandom;
      end
    end
    flush();

    // Backpressure: five words, consumer stalled for four cycles
    for (int i = 0; i < 5; i++) begin
      bp_fmt[i] = 3'($urandom_range(0, 4));
      bp_imm[i] = rnd_imm();
    end
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, bp_fmt[idx], bp_imm[idx], 32'h100 + 32'(idx), 1'b0);
      if (acc) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 20 && idx < 5; i++) begin
      cyc(1'b1, bp_fmt[idx], bp_imm[idx], 32'h100 + 32'(idx), 1'b1);
      if (acc) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd5);
    flush();

    // Saturation of the error counter
    sent = 0;
    for (int i = 0; i < 400 && sent < 300; i++) begin
      cyc(1'b1, 3'd7, $urandom, $urandom, 1'b1);
      if (acc) sent++;
    end
    chk("sat_sent", 32'(sent), 32'd300);
    flush();
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("err_count_sat", 32'(bus.err_count), 32'(CNT_MAX));

    // Reset with two words in flight
    cyc(1'b1, 3'd5, 32'd0, 32'h1111_1111, 1'b0);
    cyc(1'b1, 3'd0, 32'd5, 32'h2222_2222, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_instr", bus.out_instr, 32'd0);
    chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    sb_q.delete();
    model_cnt  = 0;
    stall_prev = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end
    chk("post_rst_err_count", 32'(bus.err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
